// File: rtl/ps2_pad_tx.sv
// -----------------------------------------------------------------------------
// ps2_pad_tx
//
// Turns a PS/2 keyboard into the Gigatron game-controller serial stream.
// PS/2 scan-set-2 frames are received and decoded into one "held key" byte.
// The byte is either active-low buttons or ASCII. It is parallel-loaded on
// every VSYNC falling edge and shifted out MSB-first, one bit per HSYNC
// falling edge. The Gigatron input register samples each bit on the
// following HSYNC rising edge.
//
// Ports
//   CLK           in   system clock, everything on the rising edge
//   RST_N         in   synchronous active-low reset
//   KBCLK         in   PS/2 clock (async, idle high)
//   KBDTA         in   PS/2 data  (async, idle high)
//   HSYNC         in   Gigatron HSYNC (async), falling edge = shift
//   VSYNC         in   Gigatron VSYNC (async), falling edge = latch
//   SER_DATA      out  serial controller data, MSB first
//   KEY_CODE      out  currently held key byte, 0xFF when idle
//   FRAME_ERR     out  one-cycle pulse on start/parity/stop/timeout error
//   DBG_RX_STATE  out  PS/2 receiver FSM state (0 idle, 1 data, 2 parity, 3 stop)
//
// Internal byte strobe: rx_byte_vld is high for exactly one cycle, and
// rx_shift_q holds the received byte during that cycle. No back-pressure
// exists. The decoder consumes the byte in that same cycle.
// -----------------------------------------------------------------------------
module ps2_pad_tx #(
   parameter int PS2_TIMEOUT = 6250,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       KBCLK,
   input  logic       KBDTA,
   input  logic       HSYNC,
   input  logic       VSYNC,
   output logic       SER_DATA,
   output logic [7:0] KEY_CODE,
   output logic       FRAME_ERR,
   output logic [1:0] DBG_RX_STATE
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam int TW = $clog2(PS2_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(PS2_TIMEOUT - 1);

   // ---------------------------------------------------------------------------
   // Input synchronisers. Bit order is {KBCLK, KBDTA, HSYNC, VSYNC}.
   // Every stage resets to 1 because all four lines idle high. This means
   // leaving reset never produces a false falling edge.
   // ---------------------------------------------------------------------------
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_s;
   logic       kbclk_prev_q, hsync_prev_q, vsync_prev_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
         kbclk_prev_q <= 1'b1;
         hsync_prev_q <= 1'b1;
         vsync_prev_q <= 1'b1;
      end else begin
         sync_q[0] <= {KBCLK, KBDTA, HSYNC, VSYNC};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         kbclk_prev_q <= sync_s[3];
         hsync_prev_q <= sync_s[1];
         vsync_prev_q <= sync_s[0];
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   logic kbclk_fall, kbdta_s, hsync_fall, vsync_fall;
   assign kbclk_fall = kbclk_prev_q & ~sync_s[3];
   assign kbdta_s    = sync_s[2];
   assign hsync_fall = hsync_prev_q & ~sync_s[1];
   assign vsync_fall = vsync_prev_q & ~sync_s[0];

   // ---------------------------------------------------------------------------
   // PS/2 receiver
   // ---------------------------------------------------------------------------
   logic [1:0]    rx_state_q, rx_state_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          rx_byte_vld, rx_err;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_shift_d  = rx_shift_q;
      bitcnt_d    = bitcnt_q;
      par_ok_d    = par_ok_q;
      tmo_d       = tmo_q;
      rx_byte_vld = 1'b0;
      rx_err      = 1'b0;
      if (kbclk_fall) begin
         tmo_d = '0;
         case (rx_state_q)
            ST_IDLE: begin
               // A 1 while idle is line noise or a glitch. Ignore it silently.
               if (!kbdta_s) begin
                  rx_state_d = ST_DATA;
                  bitcnt_d   = 3'd0;
                  rx_shift_d = 8'h00;
               end
            end
            ST_DATA: begin
               rx_shift_d = {kbdta_s, rx_shift_q[7:1]};
               bitcnt_d   = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) rx_state_d = ST_PARITY;
            end
            ST_PARITY: begin
               // Data plus parity must have odd weight.
               par_ok_d   = ^{rx_shift_q, kbdta_s};
               rx_state_d = ST_STOP;
            end
            default: begin
               if (kbdta_s && par_ok_q) rx_byte_vld = 1'b1;
               else                     rx_err      = 1'b1;
               rx_state_d = ST_IDLE;
            end
         endcase
      end else if (rx_state_q != ST_IDLE) begin
         if (tmo_q == TMO_LAST) begin
            rx_err     = 1'b1;
            rx_state_d = ST_IDLE;
            tmo_d      = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rx_state_q <= ST_IDLE;
         rx_shift_q <= 8'h00;
         bitcnt_q   <= 3'd0;
         par_ok_q   <= 1'b0;
         tmo_q      <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         bitcnt_q   <= bitcnt_d;
         par_ok_q   <= par_ok_d;
         tmo_q      <= tmo_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Scan-code decoder. The result is {hit, value}.
   // ---------------------------------------------------------------------------
   function automatic logic [8:0] key_lookup(input logic ext, input logic [7:0] code);
      logic [8:0] r;
      r = {1'b0, 8'hFF};
      if (ext) begin
         case (code)
            8'h75:   r = {1'b1, 8'hF7};   // up
            8'h72:   r = {1'b1, 8'hFB};   // down
            8'h6B:   r = {1'b1, 8'hFD};   // left
            8'h74:   r = {1'b1, 8'hFE};   // right
            default: r = {1'b0, 8'hFF};
         endcase
      end else begin
         case (code)
            8'h05:   r = {1'b1, 8'h7F};   // F1 -> A
            8'h06:   r = {1'b1, 8'hBF};   // F2 -> B
            8'h04:   r = {1'b1, 8'hDF};   // F3 -> Select
            8'h0C:   r = {1'b1, 8'hEF};   // F4 -> Start
            8'h1C:   r = {1'b1, 8'h61};   // a
            8'h32:   r = {1'b1, 8'h62};
            8'h21:   r = {1'b1, 8'h63};
            8'h23:   r = {1'b1, 8'h64};
            8'h24:   r = {1'b1, 8'h65};
            8'h2B:   r = {1'b1, 8'h66};
            8'h34:   r = {1'b1, 8'h67};
            8'h33:   r = {1'b1, 8'h68};
            8'h43:   r = {1'b1, 8'h69};
            8'h3B:   r = {1'b1, 8'h6A};
            8'h42:   r = {1'b1, 8'h6B};
            8'h4B:   r = {1'b1, 8'h6C};
            8'h3A:   r = {1'b1, 8'h6D};
            8'h31:   r = {1'b1, 8'h6E};
            8'h44:   r = {1'b1, 8'h6F};
            8'h4D:   r = {1'b1, 8'h70};
            8'h15:   r = {1'b1, 8'h71};
            8'h2D:   r = {1'b1, 8'h72};
            8'h1B:   r = {1'b1, 8'h73};
            8'h2C:   r = {1'b1, 8'h74};
            8'h3C:   r = {1'b1, 8'h75};
            8'h2A:   r = {1'b1, 8'h76};
            8'h1D:   r = {1'b1, 8'h77};
            8'h22:   r = {1'b1, 8'h78};
            8'h35:   r = {1'b1, 8'h79};
            8'h1A:   r = {1'b1, 8'h7A};   // z
            8'h45:   r = {1'b1, 8'h30};   // 0
            8'h16:   r = {1'b1, 8'h31};
            8'h1E:   r = {1'b1, 8'h32};
            8'h26:   r = {1'b1, 8'h33};
            8'h25:   r = {1'b1, 8'h34};
            8'h2E:   r = {1'b1, 8'h35};
            8'h36:   r = {1'b1, 8'h36};
            8'h3D:   r = {1'b1, 8'h37};
            8'h3E:   r = {1'b1, 8'h38};
            8'h46:   r = {1'b1, 8'h39};   // 9
            8'h29:   r = {1'b1, 8'h20};   // space
            8'h5A:   r = {1'b1, 8'h0A};   // enter
            8'h66:   r = {1'b1, 8'h7F};   // backspace (same byte as F1 on purpose)
            default: r = {1'b0, 8'hFF};
         endcase
      end
      return r;
   endfunction

   logic       ext_q, brk_q;
   logic [7:0] key_q;
   logic [8:0] lut;

   assign lut = key_lookup(ext_q, rx_shift_q);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         key_q <= 8'hFF;
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (rx_err) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (rx_byte_vld) begin
         if (rx_shift_q == 8'hE0) begin
            ext_q <= 1'b1;
         end else if (rx_shift_q == 8'hF0) begin
            brk_q <= 1'b1;
         end else begin
            if (lut[8]) begin
               // A release only clears the key if it is the one being held.
               if (!brk_q)               key_q <= lut[7:0];
               else if (key_q == lut[7:0]) key_q <= 8'hFF;
            end
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Serial transmitter. When latch and shift coincide, the latch wins.
   // Ones are shifted in, so the register drains to all ones after 8 bits.
   // ---------------------------------------------------------------------------
   logic [7:0] sreg_q;
   logic [3:0] shcnt_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sreg_q  <= 8'hFF;
         shcnt_q <= 4'd0;
      end else if (vsync_fall) begin
         sreg_q  <= key_q;
         shcnt_q <= 4'd0;
      end else if (hsync_fall) begin
         sreg_q <= {sreg_q[6:0], 1'b1};
         if (shcnt_q != 4'd8) shcnt_q <= shcnt_q + 4'd1;
      end
   end

   assign SER_DATA     = sreg_q[7];
   assign KEY_CODE     = key_q;
   assign DBG_RX_STATE = rx_state_q;

   logic frame_err_q;
   always_ff @(posedge CLK) begin
      if (!RST_N) frame_err_q <= 1'b0;
      else        frame_err_q <= rx_err;
   end
   assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_ps2_pad_tx.sv
module tb_ps2_pad_tx;

   logic       clk = 1'b0;
   logic       rst_n, kbclk, kbdta, hsync, vsync;
   logic       ser_data, frame_err;
   logic [7:0] key_code;
   logic [1:0] dbg_state;

   int tests = 0;
   int fails = 0;
   int ferr_cnt = 0;

   always #5 clk = ~clk;

   ps2_pad_tx #(.PS2_TIMEOUT(200), .SYNC_STAGES(2)) dut (
      .CLK(clk), .RST_N(rst_n), .KBCLK(kbclk), .KBDTA(kbdta),
      .HSYNC(hsync), .VSYNC(vsync), .SER_DATA(ser_data),
      .KEY_CODE(key_code), .FRAME_ERR(frame_err), .DBG_RX_STATE(dbg_state)
   );

   // Count FRAME_ERR high cycles. One error must give exactly one cycle.
   always @(negedge clk) if (rst_n && frame_err) ferr_cnt++;

   typedef struct {
      logic [7:0] code;
      logic [7:0] exp_key;
      logic       do_cap;
   } vec_t;

   vec_t vecs[22];

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Send the first nbits of an 11-bit PS/2 frame.
   task automatic ps2_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         kbdta = f[i];
         cyc(5);
         kbclk = 1'b0;
         cyc(10);
         kbclk = 1'b1;
         cyc(5);
      end
      kbdta = 1'b1;
      cyc(10);
   endtask

   // One VSYNC latch followed by 8 bit periods. The bit is captured
   // before each HSYNC falling edge, as the Gigatron does on HSYNC rising.
   task automatic capture(output logic [7:0] cap);
      cap = 8'h00;
      vsync = 1'b0;
      cyc(6);
      vsync = 1'b1;
      cyc(2);
      for (int i = 0; i < 8; i++) begin
         cap = {cap[6:0], ser_data};
         hsync = 1'b0;
         cyc(6);
         hsync = 1'b1;
         cyc(6);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(4);
      rst_n = 1'b1;
      cyc(2);
   endtask

   initial begin
      logic [7:0] cap;
      int         e0;

      vecs[0]  = '{8'h1C, 8'h61, 1'b1};  // a
      vecs[1]  = '{8'hF0, 8'h61, 1'b0};
      vecs[2]  = '{8'h1C, 8'hFF, 1'b1};  // release a
      vecs[3]  = '{8'hE0, 8'hFF, 1'b0};
      vecs[4]  = '{8'h75, 8'hF7, 1'b1};  // up
      vecs[5]  = '{8'hE0, 8'hF7, 1'b0};
      vecs[6]  = '{8'hF0, 8'hF7, 1'b0};
      vecs[7]  = '{8'h75, 8'hFF, 1'b1};  // release up
      vecs[8]  = '{8'h1C, 8'h61, 1'b0};  // press a
      vecs[9]  = '{8'h05, 8'h7F, 1'b0};  // press F1
      vecs[10] = '{8'hF0, 8'h7F, 1'b0};
      vecs[11] = '{8'h1C, 8'h7F, 1'b1};  // release a, F1 stays
      vecs[12] = '{8'h45, 8'h30, 1'b0};  // 0
      vecs[13] = '{8'h76, 8'h30, 1'b0};  // unmapped
      vecs[14] = '{8'h5A, 8'h0A, 1'b1};  // enter
      vecs[15] = '{8'hE0, 8'h0A, 1'b0};
      vecs[16] = '{8'h6B, 8'hFD, 1'b0};  // left
      vecs[17] = '{8'h04, 8'hDF, 1'b0};  // F3, ext already cleared
      vecs[18] = '{8'hF0, 8'hDF, 1'b0};
      vecs[19] = '{8'h0C, 8'hDF, 1'b0};  // release of a key not held
      vecs[20] = '{8'h0C, 8'hEF, 1'b0};  // F4
      vecs[21] = '{8'h1A, 8'h7A, 1'b1};  // z

      kbclk = 1'b1; kbdta = 1'b1; hsync = 1'b1; vsync = 1'b1;
      do_reset();
      check8("reset_key", key_code, 8'hFF);
      check8("reset_ser", {7'd0, ser_data}, 8'h01);
      check8("reset_ferr", {7'd0, frame_err}, 8'h00);
      check8("reset_rx_state", {6'd0, dbg_state}, 8'h00);

      // Idle frames with no key pressed.
      for (int f = 0; f < 3; f++) begin
         capture(cap);
         check8($sformatf("idle_cap%0d", f), cap, 8'hFF);
      end
      check8("idle_key", key_code, 8'hFF);
      check8("idle_ferr_cnt", ferr_cnt[7:0], 8'h00);

      // Table of single scan bytes.
      for (int i = 0; i < 22; i++) begin
         ps2_frame(vecs[i].code, 1'b0, 1'b0, 11);
         check8($sformatf("vec%0d_key_%02h", i, vecs[i].code), key_code, vecs[i].exp_key);
         if (vecs[i].do_cap) begin
            capture(cap);
            check8($sformatf("vec%0d_cap", i), cap, vecs[i].exp_key);
         end
      end
      check8("table_ferr_cnt", ferr_cnt[7:0], 8'h00);

      // Error frames. Each one gives one FRAME_ERR cycle, and the key holds at 0x7A.
      e0 = ferr_cnt;
      ps2_frame(8'h1C, 1'b1, 1'b0, 11);
      check8("badpar_ferr", 8'(ferr_cnt - e0), 8'h01);
      check8("badpar_key", key_code, 8'h7A);
      e0 = ferr_cnt;
      ps2_frame(8'h1C, 1'b0, 1'b1, 11);
      check8("badstop_ferr", 8'(ferr_cnt - e0), 8'h01);
      check8("badstop_key", key_code, 8'h7A);
      e0 = ferr_cnt;
      ps2_frame(8'h1C, 1'b0, 1'b0, 4);
      check8("stall_state_data", {6'd0, dbg_state}, 8'h01);
      cyc(300);
      check8("timeout_ferr", 8'(ferr_cnt - e0), 8'h01);
      check8("timeout_state", {6'd0, dbg_state}, 8'h00);
      check8("timeout_key", key_code, 8'h7A);
      // An error clears a pending E0, so 0x75 decodes as an unmapped plain code.
      ps2_frame(8'hE0, 1'b0, 1'b0, 11);
      ps2_frame(8'h1C, 1'b1, 1'b0, 11);
      ps2_frame(8'h75, 1'b0, 1'b0, 11);
      check8("err_clears_ext", key_code, 8'h7A);
      ps2_frame(8'h29, 1'b0, 1'b0, 11);
      check8("space_key", key_code, 8'h20);

      // Simultaneous VSYNC and HSYNC falling: the latch wins.
      ps2_frame(8'h06, 1'b0, 1'b0, 11);
      check8("f2_key", key_code, 8'hBF);
      vsync = 1'b0; hsync = 1'b0;
      cyc(6);
      check8("latch_wins_bit7", {7'd0, ser_data}, 8'h01);
      vsync = 1'b1; hsync = 1'b1;
      cyc(6);
      hsync = 1'b0;
      cyc(6);
      check8("latch_bit6", {7'd0, ser_data}, 8'h00);
      hsync = 1'b1;
      cyc(6);
      vsync = 1'b0;
      cyc(6);
      check8("reload_msb", {7'd0, ser_data}, 8'h01);
      vsync = 1'b1;
      cyc(6);
      hsync = 1'b0;
      cyc(6);
      check8("reload_bit6", {7'd0, ser_data}, 8'h00);
      hsync = 1'b1;
      cyc(6);

      // Reset while the receiver is in PARITY.
      ps2_frame(8'h1C, 1'b0, 1'b0, 9);
      check8("pre_rst_parity_state", {6'd0, dbg_state}, 8'h02);
      do_reset();
      check8("rst_parity_state", {6'd0, dbg_state}, 8'h00);
      check8("rst_parity_key", key_code, 8'hFF);
      check8("rst_parity_ser", {7'd0, ser_data}, 8'h01);
      ps2_frame(8'h1C, 1'b0, 1'b0, 11);
      check8("post_rst_rx", key_code, 8'h61);

      // Reset in the middle of a shift (0xF7 -> bit 3 is 0 on the line).
      ps2_frame(8'hE0, 1'b0, 1'b0, 11);
      ps2_frame(8'h75, 1'b0, 1'b0, 11);
      check8("up_key", key_code, 8'hF7);
      vsync = 1'b0;
      cyc(6);
      vsync = 1'b1;
      for (int i = 0; i < 4; i++) begin
         hsync = 1'b0;
         cyc(6);
         hsync = 1'b1;
         cyc(6);
      end
      check8("midshift_bit3", {7'd0, ser_data}, 8'h00);
      do_reset();
      check8("rst_shift_ser", {7'd0, ser_data}, 8'h01);
      check8("rst_shift_key", key_code, 8'hFF);
      check8("rst_shift_state", {6'd0, dbg_state}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
